// File: rtl/bt_pkg.sv
// Shared constants and state encoding for the CAN bit timing logic.
package bt_pkg;

    localparam int unsigned BRP_W   = 6;
    localparam int unsigned TSEG1_W = 4;
    localparam int unsigned TSEG2_W = 3;
    localparam int unsigned SJW_W   = 2;
    localparam int unsigned TQCNT_W = 5;

    typedef logic [1:0] bt_state_t;

    localparam bt_state_t SYNC  = 2'd0;
    localparam bt_state_t TSEG1 = 2'd1;
    localparam bt_state_t TSEG2 = 2'd2;

    function automatic logic [TQCNT_W-1:0] min_tq(input logic [TQCNT_W-1:0] a,
                                                  input logic [TQCNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bt_prescaler.sv
// Time-quantum prescaler: one tick every brp+1 clocks, restartable at 0.
module bt_prescaler
    import bt_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [BRP_W-1:0] brp,
    output logic             tick
);

    logic [BRP_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == brp);

    always_comb begin
        cnt_d = cnt_q + BRP_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_timing.sv
// CAN bit timing: SYNC/TSEG1/TSEG2 sequencing with hard sync and resync,
// producing the sample point and transmit update strobes.
module bit_timing
    import bt_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               rx,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hardsync,
    output logic               sampledbit,
    output logic               sample,
    output logic               txpoint
);

    logic               sync1_q, rxs_q, start_q;
    bt_state_t          state_q, state_d;
    logic [TQCNT_W-1:0] tq_cnt_q, tq_cnt_d;
    logic [TQCNT_W-1:0] lim_q, lim_d;
    logic               resync_q, resync_d;
    logic [BRP_W-1:0]   brp_q;
    logic [TSEG1_W-1:0] tseg1_q;
    logic [TSEG2_W-1:0] tseg2_q;
    logic [SJW_W-1:0]   sjw_q;
    logic               sampledbit_q, sample_q, txpoint_q;

    logic               tick, restart, enter_sync, enter_tseg2, edge_det;
    logic [TQCNT_W-1:0] sjw_tq, e_tq, r_tq, adj, lim_eff;

    // rxs is about to go 1->0 on the next clock
    assign edge_det = rxs_q & ~sync1_q;
    assign sjw_tq   = TQCNT_W'(sjw_q) + TQCNT_W'(1);
    assign e_tq     = tq_cnt_q + TQCNT_W'(1);
    assign r_tq     = lim_q + TQCNT_W'(1) - tq_cnt_q;

    bt_prescaler u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .brp     (brp_q),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        tq_cnt_d    = tq_cnt_q;
        lim_d       = lim_q;
        resync_d    = resync_q;
        restart     = 1'b0;
        enter_sync  = 1'b0;
        enter_tseg2 = 1'b0;
        adj         = '0;
        lim_eff     = lim_q;
        // start_q begins the first bit on the clock after reset release
        if (start_q || (hardsync && edge_det)) begin
            restart    = 1'b1;
            enter_sync = 1'b1;
            resync_d   = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (tick) begin
                        state_d  = TSEG1;
                        tq_cnt_d = '0;
                        lim_d    = TQCNT_W'(tseg1_q);
                    end
                end
                TSEG1: begin
                    if (edge_det && !resync_q) begin
                        adj      = min_tq(e_tq, sjw_tq);
                        lim_eff  = lim_q + adj;
                        lim_d    = lim_eff;
                        resync_d = 1'b1;
                    end
                    if (tick) begin
                        if (tq_cnt_q == lim_eff) begin
                            enter_tseg2 = 1'b1;
                        end else begin
                            tq_cnt_d = tq_cnt_q + TQCNT_W'(1);
                        end
                    end
                end
                TSEG2: begin
                    if (edge_det && !resync_q) begin
                        adj      = min_tq(r_tq, sjw_tq);
                        resync_d = 1'b1;
                        if (adj >= r_tq) begin
                            restart    = 1'b1;
                            enter_sync = 1'b1;
                        end else begin
                            lim_eff = lim_q - adj;
                            lim_d   = lim_eff;
                        end
                    end
                    if (tick && !enter_sync) begin
                        if (tq_cnt_q == lim_eff) begin
                            enter_sync = 1'b1;
                        end else begin
                            tq_cnt_d = tq_cnt_q + TQCNT_W'(1);
                        end
                    end
                end
                default: begin
                    restart    = 1'b1;
                    enter_sync = 1'b1;
                end
            endcase
        end
        if (enter_sync) begin
            state_d  = SYNC;
            tq_cnt_d = '0;
        end
        if (enter_tseg2) begin
            state_d  = TSEG2;
            tq_cnt_d = '0;
            lim_d    = TQCNT_W'(tseg2_q);
            resync_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            start_q      <= 1'b1;
            state_q      <= SYNC;
            tq_cnt_q     <= '0;
            lim_q        <= '0;
            resync_q     <= 1'b0;
            brp_q        <= '0;
            tseg1_q      <= '0;
            tseg2_q      <= '0;
            sjw_q        <= '0;
            sampledbit_q <= 1'b1;
            sample_q     <= 1'b0;
            txpoint_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rxs_q     <= sync1_q;
            start_q   <= 1'b0;
            state_q   <= state_d;
            tq_cnt_q  <= tq_cnt_d;
            lim_q     <= lim_d;
            resync_q  <= resync_d;
            sample_q  <= enter_tseg2;
            txpoint_q <= enter_sync;
            if (enter_tseg2) begin
                sampledbit_q <= rxs_q;
            end
            // timing config is frozen for the whole bit
            if (enter_sync) begin
                brp_q   <= brp;
                tseg1_q <= tseg1;
                tseg2_q <= tseg2;
                sjw_q   <= sjw;
            end
        end
    end

    assign sampledbit = sampledbit_q;
    assign sample     = sample_q;
    assign txpoint    = txpoint_q;

endmodule

// File: tb/tb_bit_timing.sv
// Scoreboard bench for bit_timing: per-bit length, sample offset and sampled value.
module tb_bit_timing;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [5:0] brp = 6'd0;
    logic [3:0] tseg1 = 4'd3;
    logic [2:0] tseg2 = 3'd2;
    logic [1:0] sjw = 2'd0;
    logic       hardsync = 1'b0;
    logic       sampledbit, sample, txpoint;

    typedef struct {
        int   len;
        int   off;
        logic sbit;
    } bit_exp_t;

    bit_exp_t exp_q[$];
    int       n_checks = 0;
    int       n_pass = 0;

    bit_timing dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .brp        (brp),
        .tseg1      (tseg1),
        .tseg2      (tseg2),
        .sjw        (sjw),
        .hardsync   (hardsync),
        .sampledbit (sampledbit),
        .sample     (sample),
        .txpoint    (txpoint)
    );

    initial forever #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Bit length is counted txpoint to txpoint; sample offset from the bit's txpoint.
    initial begin : monitor
        int since_tx;
        since_tx = 0;
        forever begin
            @(negedge clock);
            since_tx++;
            if (sample && exp_q.size() > 0) begin
                check_eq("smp_off", since_tx, exp_q[0].off);
                check_eq("smp_bit", int'(sampledbit), int'(exp_q[0].sbit));
            end
            if (txpoint) begin
                if (exp_q.size() > 0) begin
                    check_eq("bit_len", since_tx, exp_q[0].len);
                    void'(exp_q.pop_front());
                end
                since_tx = 0;
            end
        end
    end

    task automatic wait_tx();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!txpoint && n < 100);
        check_eq("tx_seen", int'(txpoint), 1);
    endtask

    task automatic start_bit(input int len, input int off, input logic sbit);
        bit_exp_t e;
        wait_tx();
        #1;
        e.len  = len;
        e.off  = off;
        e.sbit = sbit;
        exp_q.push_back(e);
    endtask

    // Advance to just after the n-th rising edge of the current bit.
    task automatic step_to(inout int cur, input int n);
        if (n > cur) begin
            repeat (n - cur) @(posedge clock);
            #1;
            cur = n;
        end
    endtask

    task automatic run_bit(input int f1, input int r1, input int f2,
                           input int len, input int off, input logic sbit);
        int cur;
        cur = 0;
        start_bit(len, off, sbit);
        if (f1 >= 0) begin
            step_to(cur, f1);
            rx = 1'b0;
        end
        if (r1 >= 0) begin
            step_to(cur, r1);
            rx = 1'b1;
        end
        if (f2 >= 0) begin
            step_to(cur, f2);
            rx = 1'b0;
        end
    endtask

    task automatic drain();
        wait_tx();
        #1;
        check_eq("queue_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        int d;
        // reset state and first bit after release
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_sbit", int'(sampledbit), 1);
        check_eq("rst_smp", int'(sample), 0);
        check_eq("rst_tx", int'(txpoint), 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rel_tx", int'(txpoint), 1);

        // brp=0 tseg1=3 tseg2=2, idle bus: 8-clock bits, sample at +5
        repeat (3) run_bit(-1, -1, -1, 8, 5, 1'b1);

        // hard sync on a fall in TSEG2
        hardsync = 1'b1;
        wait_tx();
        repeat (5) @(posedge clock);
        #1 rx = 1'b0;
        d = 0;
        do begin
            @(negedge clock);
            if (!txpoint) d++;
        end while (!txpoint && d < 40);
        check_eq("hs_delay", d, 2);
        #1;
        begin
            bit_exp_t e;
            e.len = 8; e.off = 5; e.sbit = 1'b0;
            exp_q.push_back(e);
        end
        hardsync = 1'b0;
        drain();

        // one-clock reset mid-TSEG1 while sampledbit holds 0
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("mid_rst_sbit", int'(sampledbit), 1);
        check_eq("mid_rst_smp", int'(sample), 0);
        check_eq("mid_rst_tx", int'(txpoint), 0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("mid_rel_tx", int'(txpoint), 1);
        #1;
        begin
            bit_exp_t e;
            e.len = 8; e.off = 5; e.sbit = 1'b0;
            exp_q.push_back(e);
        end
        run_bit(-1, 0, -1, 8, 5, 1'b1);

        // config change mid-bit only takes effect at the next SYNC
        start_bit(8, 5, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        brp = 6'd1; tseg1 = 4'd7; tseg2 = 3'd3; sjw = 2'd0;
        run_bit(-1, -1, -1, 26, 18, 1'b1);

        // TSEG1 resync, 2 tq in, sjw=0: +1 tq; next bit nominal
        run_bit(5, -1, -1, 28, 20, 1'b0);
        run_bit(-1, -1, -1, 26, 18, 1'b0);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        // second fall in the same bit is ignored
        run_bit(5, 8, 11, 28, 20, 1'b0);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        // fall during SYNC: no adjustment
        run_bit(0, -1, -1, 26, 18, 1'b0);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        // TSEG2 fall at its first tq, sjw=0: shortened by 1 tq
        run_bit(17, -1, -1, 24, 18, 1'b1);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        sjw = 2'd3;
        // TSEG2 fall with one full tq left, sjw=3: straight to SYNC, 12 tq
        run_bit(22, -1, -1, 24, 18, 1'b1);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        // TSEG1 fall 1 tq in, sjw=3: lengthened by e=2 tq
        run_bit(3, -1, -1, 30, 22, 1'b0);
        run_bit(-1, 0, -1, 26, 18, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bit_timing.md
BIT_TIMING -- requirements
Module: bit_timing

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
 - clock  in  1  system clock; all logic on the rising edge.
 - reset  in  1  synchronous, active-low.
 - rx  in  1  raw CAN bus input; 1 = recessive.
 - brp  in  6  prescaler; one time quantum (tq) = brp+1 clocks.
 - tseg1  in  4  TSEG1 length = tseg1+1 tq.
 - tseg2  in  3  TSEG2 length = tseg2+1 tq.
 - sjw  in  2  sync jump width = sjw+1 tq.
 - hardsync  in  1  MACFSM: hard sync enable (idle / SOF wait).
 - sampledbit  out  1  bit value at the sample point; feeds destuffing bitin.
 - sample  out  1  one-clock strobe at the sample point; feeds destuffing activ.
 - txpoint  out  1  one-clock strobe at the start of SYNC_SEG; transmit update point.
REQ-002 SHALL use reset: reset, synchronous, active-low; clock: clock.

Function
REQ-003 SHALL pass rx through a 2-flop synchronizer; all further use is of the synchronized value rxs.
REQ-004 SHALL detect an edge when rxs goes 1->0 between consecutive clocks; no other transition counts as an edge.
REQ-005 SHALL generate a tq tick every brp+1 clocks from a prescaler counter; a counter restart by any sync SHALL restart the prescaler at 0.
REQ-006 SHALL run the FSM SYNC (1 tq) -> TSEG1 -> TSEG2 -> SYNC, advancing on tq ticks only.
REQ-007 SHALL assert sample for exactly one clock on the first clock of TSEG2 and load sampledbit with rxs on that same edge.
REQ-008 SHALL assert txpoint for exactly one clock on the first clock of SYNC.
REQ-009 Hard sync: if hardsync=1 and an edge occurs, the FSM SHALL enter SYNC on the next clock with the prescaler and tq counter cleared, regardless of the current state.
REQ-010 Resync, edge in TSEG1 (hardsync=0): TSEG1 SHALL be lengthened by min(e, sjw+1) tq, where e = number of whole tq elapsed in TSEG1 at the edge, plus 1.
REQ-011 Resync, edge in TSEG2 (hardsync=0): TSEG2 SHALL be shortened by min(r, sjw+1) tq, where r = tq remaining in TSEG2; if the shortening is >= r, the next clock SHALL be SYNC.
REQ-012 An edge in SYNC SHALL cause no adjustment.
REQ-013 SHALL perform at most one resync per bit; the resync flag clears at the sample point.
REQ-014 Hard sync SHALL take priority over resync when both apply.
REQ-015 SHALL sample the config inputs (brp, tseg1, tseg2, sjw) at each SYNC entry and hold them for the rest of the bit; changes mid-bit SHALL NOT affect the current bit.
REQ-016 SHALL use an internal tq counter 5 bits wide so that tseg1+1+sjw+1 (max 20) cannot wrap.

Reset
REQ-017 With reset=0 at a clock edge, the next-state values SHALL be: state SYNC, prescaler 0, tq counter 0, resync flag 0, sampledbit 1, sample 0, txpoint 0, synchronizer flops 1.
REQ-018 Reset asserted mid-bit SHALL abort the bit; no sample or txpoint strobe SHALL appear in the cycle after reset.

Structure
REQ-019 Package bt_pkg SHALL hold the state encoding (SYNC, TSEG1, TSEG2) and the width constants (BRP_W=6, TSEG1_W=4, TSEG2_W=3, SJW_W=2, TQCNT_W=5).
REQ-020 The prescaler SHALL be a sub-module, bt_prescaler (inputs clock, reset, restart, brp; output tick).

Verification
REQ-021 brp=0, tseg1=3, tseg2=2, rx=1 constant -> sample every 8 clocks, txpoint every 8 clocks, 5 clocks after each txpoint, sampledbit=1.
REQ-022 Same config, hardsync=1, rx 1->0 mid-TSEG2 -> txpoint 2 clocks after the rx change (synchronizer delay), sample 5 clocks later, sampledbit=0.
REQ-023 brp=1, tseg1=7, tseg2=3, sjw=0, edge 2 tq into TSEG1 -> that bit lasts 14 tq = 28 clocks; the following bit lasts 13 tq.
REQ-024 Same config, sjw=3, edge with 1 tq left in TSEG2 -> next clock is SYNC; that bit lasts 12 tq.
REQ-025 A second edge in the same bit after a resync -> no further length change.
REQ-026 reset=0 for one clock mid-TSEG1 -> sampledbit=1, no strobe in the next cycle, first txpoint one cycle after release.
